// File: rtl/csr_file_pkg.sv
//------------------------------------------------------------------------------
// Module  : csr_file_pkg
// Brief   : Shared types for the M-mode CSR file: op codes, CSR ids, mcause.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_t;

    typedef enum logic [11:0] {
        CSR_MSTATUS       = 12'h300,
        CSR_MISA          = 12'h301,
        CSR_MIE           = 12'h304,
        CSR_MTVEC         = 12'h305,
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MHPMEVENT3    = 12'h323,
        CSR_MHPMEVENT4    = 12'h324,
        CSR_MHPMEVENT5    = 12'h325,
        CSR_MHPMEVENT6    = 12'h326,
        CSR_MSCRATCH      = 12'h340,
        CSR_MEPC          = 12'h341,
        CSR_MCAUSE        = 12'h342,
        CSR_MTVAL         = 12'h343,
        CSR_MIP           = 12'h344,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MHPMCOUNTER3  = 12'hB03,
        CSR_MHPMCOUNTER4  = 12'hB04,
        CSR_MHPMCOUNTER5  = 12'hB05,
        CSR_MHPMCOUNTER6  = 12'hB06,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_MHPMCOUNTER3H = 12'hB83,
        CSR_MHPMCOUNTER4H = 12'hB84,
        CSR_MHPMCOUNTER5H = 12'hB85,
        CSR_MHPMCOUNTER6H = 12'hB86,
        CSR_MVENDORID     = 12'hF11,
        CSR_MARCHID       = 12'hF12,
        CSR_MIMPID        = 12'hF13,
        CSR_MHARTID       = 12'hF14
    } csr_t;

    typedef struct packed {
        logic        intr;
        logic [30:0] code;
    } mcause_t;

    localparam logic [30:0] c_code_msi = 31'd3;
    localparam logic [30:0] c_code_mti = 31'd7;
    localparam logic [30:0] c_code_mei = 31'd11;
    localparam logic [31:0] c_misa     = 32'h4000_0100;

    // Interrupts: codes 0/3/7/11; exceptions: codes 0..7 and 11.
    function automatic logic mcause_legal(input logic [31:0] v);
        logic ok;
        if (v[30:4] != '0) begin
            ok = 1'b0;
        end else if (v[31]) begin
            ok = (v[3:0] == 4'd0) || (v[3:0] == 4'd3) ||
                 (v[3:0] == 4'd7) || (v[3:0] == 4'd11);
        end else begin
            ok = (v[3:0] <= 4'd7) || (v[3:0] == 4'd11);
        end
        return ok;
    endfunction

    // Counter slot k -> counter number (slot 0 = mcycle, slot 1 = minstret, then hpm3..).
    function automatic int cnt_num(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_counter64.sv
//------------------------------------------------------------------------------
// Module  : csr_counter64
// Brief   : 64-bit event counter with inhibit and 32-bit half writes that
//           take precedence over the increment in the same cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inhibit,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wd,
    output logic [63:0] value
);

    logic [63:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (wr_lo || wr_hi) begin
            // A software write suppresses the increment for the whole counter.
            if (wr_lo) r_value[31:0]  <= wd;
            if (wr_hi) r_value[63:32] <= wd;
        end else if (inc && !inhibit) begin
            r_value <= r_value + 64'd1;
        end
    end

    assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/csr_file.sv
//------------------------------------------------------------------------------
// Module  : csr_file
// Brief   : Machine-mode CSR file with trap/MRET sequencing, interrupt
//           arbitration and programmable hardware performance counters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csr_file
    import csr_file_pkg::*;
#(
    parameter int          NUM_HPM     = 3,
    parameter int          HPM_EVENTS  = 8,
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [31:0] RESET_MTVEC = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  csr_op_t               csr_op,
    input  csr_t                  csr_id,
    input  logic [31:0]           wd,
    output logic [31:0]           rd,
    output logic                  illegal,
    input  logic                  retire,
    input  logic                  trap_valid,
    input  mcause_t               trap_cause,
    input  logic [31:0]           trap_pc,
    input  logic [31:0]           trap_tval,
    input  logic                  mret,
    input  logic                  mtip,
    input  logic                  msip,
    input  logic                  meip,
    input  logic [HPM_EVENTS-1:0] hpm_event,
    output logic                  irq_take,
    output mcause_t               irq_cause,
    output logic [31:0]           trap_target
);

    localparam int          c_ncnt       = 2 + NUM_HPM;
    localparam int          c_nev        = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [63:0] c_inh_full   = (64'd1 << (NUM_HPM + 3)) - 64'd1;
    localparam logic [31:0] c_inh_mask   = c_inh_full[31:0] & 32'hFFFF_FFFD;
    localparam logic [1:0]  c_reset_mode = (VECTORED_EN && (RESET_MTVEC[1:0] == 2'b01)) ? 2'b01 : 2'b00;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [2:0]  r_mie_en;          // {meie, mtie, msie}
    logic [29:0] r_mtvec_base;
    logic [1:0]  r_mtvec_mode;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    mcause_t     r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_mcountinhibit;
    logic [31:0] r_mhpmevent [c_nev];

    logic [11:0]        w_addr;
    logic [31:0]        w_old;
    logic [31:0]        w_new;
    logic               w_impl;
    logic               w_write_attempt;
    logic               w_do_write;
    logic [63:0]        w_cnt [c_ncnt];
    logic [c_ncnt-1:0]  w_cnt_inc;
    logic [c_ncnt-1:0]  w_cnt_inh;
    logic [c_ncnt-1:0]  w_cnt_wr_lo;
    logic [c_ncnt-1:0]  w_cnt_wr_hi;
    logic               w_mei;
    logic               w_msi;
    logic               w_mti;
    logic [31:0]        w_vec_off;

    assign w_addr = csr_id;

    // Read mux and implemented-id decode.
    always_comb begin
        w_impl = 1'b1;
        w_old  = '0;
        case (csr_id)
            CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID, CSR_MHARTID:  w_old = '0;
            CSR_MSTATUS:        w_old = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
            CSR_MISA:           w_old = c_misa;
            CSR_MIE:            w_old = {20'b0, r_mie_en[2], 3'b0, r_mie_en[1], 3'b0, r_mie_en[0], 3'b0};
            CSR_MTVEC:          w_old = {r_mtvec_base, r_mtvec_mode};
            CSR_MCOUNTINHIBIT:  w_old = r_mcountinhibit;
            CSR_MSCRATCH:       w_old = r_mscratch;
            CSR_MEPC:           w_old = r_mepc;
            CSR_MCAUSE:         w_old = r_mcause;
            CSR_MTVAL:          w_old = r_mtval;
            CSR_MIP:            w_old = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
            default: begin
                w_impl = 1'b0;
                for (int k = 0; k < c_ncnt; k++) begin
                    if (w_addr == 12'hB00 + 12'(cnt_num(k))) begin
                        w_impl = 1'b1;
                        w_old  = w_cnt[k][31:0];
                    end
                    if (w_addr == 12'hB80 + 12'(cnt_num(k))) begin
                        w_impl = 1'b1;
                        w_old  = w_cnt[k][63:32];
                    end
                end
                for (int e = 0; e < NUM_HPM; e++) begin
                    if (w_addr == 12'h323 + 12'(e)) begin
                        w_impl = 1'b1;
                        w_old  = r_mhpmevent[e];
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (csr_op)
            CSR_OP_RW: w_new = wd;
            CSR_OP_RS: w_new = w_old | wd;
            CSR_OP_RC: w_new = w_old & ~wd;
            default:   w_new = w_old;
        endcase
    end

    assign w_write_attempt = (csr_op == CSR_OP_RW) ||
                             (((csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC)) && (wd != '0));
    assign illegal = (csr_op != CSR_OP_NONE) &&
                     (!w_impl || (w_write_attempt && (w_addr[11:10] == 2'b11)));
    assign rd      = illegal ? '0 : w_old;
    // Trap and MRET own the cycle; a coincident CSR write is dropped.
    assign w_do_write = w_write_attempt && !illegal && !trap_valid && !mret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie   <= 1'b0;
            r_mstatus_mpie  <= 1'b0;
            r_mie_en        <= '0;
            r_mtvec_base    <= RESET_MTVEC[31:2];
            r_mtvec_mode    <= c_reset_mode;
            r_mscratch      <= '0;
            r_mepc          <= '0;
            r_mcause        <= '0;
            r_mtval         <= '0;
            r_mcountinhibit <= '0;
            for (int e = 0; e < c_nev; e++) r_mhpmevent[e] <= '0;
        end else if (trap_valid) begin
            r_mepc         <= {trap_pc[31:2], 2'b00};
            r_mcause       <= trap_cause;
            r_mtval        <= trap_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_do_write) begin
            case (csr_id)
                CSR_MSTATUS: begin
                    r_mstatus_mie  <= w_new[3];
                    r_mstatus_mpie <= w_new[7];
                end
                CSR_MIE:           r_mie_en <= {w_new[11], w_new[7], w_new[3]};
                CSR_MTVEC: begin
                    r_mtvec_base <= w_new[31:2];
                    if ((w_new[1:0] == 2'b00) || ((w_new[1:0] == 2'b01) && VECTORED_EN))
                        r_mtvec_mode <= w_new[1:0];
                end
                CSR_MCOUNTINHIBIT: r_mcountinhibit <= w_new & c_inh_mask;
                CSR_MSCRATCH:      r_mscratch <= w_new;
                CSR_MEPC:          r_mepc <= {w_new[31:2], 2'b00};
                CSR_MCAUSE: begin
                    if (mcause_legal(w_new)) r_mcause <= w_new;
                end
                CSR_MTVAL:         r_mtval <= w_new;
                default: ;
            endcase
            for (int e = 0; e < NUM_HPM; e++) begin
                if (w_addr == 12'h323 + 12'(e))
                    r_mhpmevent[e] <= (w_new > 32'(HPM_EVENTS)) ? '0 : w_new;
            end
        end
    end

    // Counter controls; event selectors are stored legalised so 0 means idle.
    always_comb begin
        w_cnt_inc    = '0;
        w_cnt_inc[0] = 1'b1;
        w_cnt_inc[1] = retire;
        for (int e = 0; e < NUM_HPM; e++) begin
            for (int j = 0; j < HPM_EVENTS; j++) begin
                if (r_mhpmevent[e] == 32'(j + 1)) w_cnt_inc[e + 2] = hpm_event[j];
            end
        end
    end

    always_comb begin
        w_cnt_inh   = '0;
        w_cnt_wr_lo = '0;
        w_cnt_wr_hi = '0;
        for (int k = 0; k < c_ncnt; k++) begin
            w_cnt_inh[k]   = r_mcountinhibit[5'(cnt_num(k))];
            w_cnt_wr_lo[k] = w_do_write && (w_addr == 12'hB00 + 12'(cnt_num(k)));
            w_cnt_wr_hi[k] = w_do_write && (w_addr == 12'hB80 + 12'(cnt_num(k)));
        end
    end

    for (genvar gi = 0; gi < c_ncnt; gi++) begin : g_cnt
        csr_counter64 u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inhibit (w_cnt_inh[gi]),
            .inc     (w_cnt_inc[gi]),
            .wr_lo   (w_cnt_wr_lo[gi]),
            .wr_hi   (w_cnt_wr_hi[gi]),
            .wd      (w_new),
            .value   (w_cnt[gi])
        );
    end

    assign w_mei    = meip & r_mie_en[2];
    assign w_mti    = mtip & r_mie_en[1];
    assign w_msi    = msip & r_mie_en[0];
    assign irq_take = r_mstatus_mie & (w_mei | w_msi | w_mti);

    always_comb begin
        irq_cause = '0;
        if (irq_take) begin
            irq_cause.intr = 1'b1;
            if (w_mei)      irq_cause.code = c_code_mei;
            else if (w_msi) irq_cause.code = c_code_msi;
            else            irq_cause.code = c_code_mti;
        end
    end

    assign w_vec_off = ((r_mtvec_mode == 2'b01) && trap_cause.intr) ?
                       {trap_cause.code[29:0], 2'b00} : 32'd0;

    always_comb begin
        if (trap_valid)  trap_target = {r_mtvec_base, 2'b00} + w_vec_off;
        else if (mret)   trap_target = r_mepc;
        else             trap_target = {r_mtvec_base, 2'b00} + w_vec_off;
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_file.sv
//------------------------------------------------------------------------------
// Module  : tb_csr_file
// Brief   : Directed self-checking bench for csr_file (NUM_HPM=3, vectored).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_csr_file;
    import csr_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    csr_op_t     csr_op;
    csr_t        csr_id;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        illegal;
    logic        retire;
    logic        trap_valid;
    mcause_t     trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        mtip, msip, meip;
    logic [7:0]  hpm_event;
    logic        irq_take;
    mcause_t     irq_cause;
    logic [31:0] trap_target;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_file #(
        .NUM_HPM     (3),
        .HPM_EVENTS  (8),
        .VECTORED_EN (1'b1),
        .RESET_MTVEC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_op      (csr_op),
        .csr_id      (csr_id),
        .wd          (wd),
        .rd          (rd),
        .illegal     (illegal),
        .retire      (retire),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .trap_pc     (trap_pc),
        .trap_tval   (trap_tval),
        .mret        (mret),
        .mtip        (mtip),
        .msip        (msip),
        .meip        (meip),
        .hpm_event   (hpm_event),
        .irq_take    (irq_take),
        .irq_cause   (irq_cause),
        .trap_target (trap_target)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_csr(input csr_t id, output logic [31:0] val, output logic il);
        csr_op = CSR_OP_RS;
        csr_id = id;
        wd     = '0;
        #1;
        val    = rd;
        il     = illegal;
        csr_op = CSR_OP_NONE;
    endtask

    task automatic wr_csr(input csr_op_t op, input csr_t id, input logic [31:0] val);
        csr_op = op;
        csr_id = id;
        wd     = val;
        tick();
        csr_op = CSR_OP_NONE;
        wd     = '0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        il;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd_csr(CSR_MSTATUS, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mstatus: got %h want %h", v, 32'h0); end
        rd_csr(CSR_MTVEC, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mtvec: got %h want %h", v, 32'h0); end
        rd_csr(CSR_MCYCLE, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mcycle: got %h want %h", v, 32'h0); end
        checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL reset_irq_take: got %b want 0", irq_take); end
        tick();
        rd_csr(CSR_MCYCLE, v, il);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_mcycle_next: got %h want %h", v, 32'h1); end
    endtask

    task automatic test_trap_vectored();
        logic [31:0] v;
        logic        il;
        wr_csr(CSR_OP_RW, CSR_MTVEC, 32'h0000_1001);
        wr_csr(CSR_OP_RW, CSR_MIE, 32'h0000_0800);
        wr_csr(CSR_OP_RS, CSR_MSTATUS, 32'h0000_0008);
        rd_csr(CSR_MTVEC, v, il);
        checks++; if (v !== 32'h0000_1001) begin errors++; $display("FAIL mtvec_rw: got %h want %h", v, 32'h1001); end
        meip = 1'b1;
        #1;
        checks++; if (irq_take !== 1'b1) begin errors++; $display("FAIL irq_take_mei: got %b want 1", irq_take); end
        checks++; if (irq_cause !== 32'h8000_000B) begin errors++; $display("FAIL irq_cause_mei: got %h want %h", irq_cause, 32'h8000_000B); end
        trap_cause = 32'h8000_000B;
        trap_pc    = 32'h0000_2346;
        trap_tval  = 32'h1234_5678;
        trap_valid = 1'b1;
        #1;
        checks++; if (trap_target !== 32'h0000_102C) begin errors++; $display("FAIL trap_target_vec: got %h want %h", trap_target, 32'h102C); end
        tick();
        trap_valid = 1'b0;
        rd_csr(CSR_MEPC, v, il);
        checks++; if (v !== 32'h0000_2344) begin errors++; $display("FAIL trap_mepc: got %h want %h", v, 32'h2344); end
        rd_csr(CSR_MCAUSE, v, il);
        checks++; if (v !== 32'h8000_000B) begin errors++; $display("FAIL trap_mcause: got %h want %h", v, 32'h8000_000B); end
        rd_csr(CSR_MTVAL, v, il);
        checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL trap_mtval: got %h want %h", v, 32'h1234_5678); end
        rd_csr(CSR_MSTATUS, v, il);
        checks++; if (v !== 32'h0000_0080) begin errors++; $display("FAIL trap_mstatus: got %h want %h", v, 32'h80); end
        checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL irq_masked_after_trap: got %b want 0", irq_take); end
        meip       = 1'b0;
        trap_cause = 32'h0000_0002;
        #1;
        checks++; if (trap_target !== 32'h0000_1000) begin errors++; $display("FAIL trap_target_exc: got %h want %h", trap_target, 32'h1000); end
    endtask

    task automatic test_mret_priority();
        logic [31:0] v;
        logic        il;
        mret   = 1'b1;
        csr_op = CSR_OP_RW;
        csr_id = CSR_MSCRATCH;
        wd     = 32'd5;
        #1;
        checks++; if (trap_target !== 32'h0000_2344) begin errors++; $display("FAIL mret_target: got %h want %h", trap_target, 32'h2344); end
        tick();
        mret   = 1'b0;
        csr_op = CSR_OP_NONE;
        wd     = '0;
        rd_csr(CSR_MSTATUS, v, il);
        checks++; if (v !== 32'h0000_0088) begin errors++; $display("FAIL mret_mstatus: got %h want %h", v, 32'h88); end
        rd_csr(CSR_MSCRATCH, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mret_drops_write: got %h want %h", v, 32'h0); end
    endtask

    task automatic test_irq_priority();
        wr_csr(CSR_OP_RW, CSR_MIE, 32'h0000_0888);
        meip = 1'b1; msip = 1'b1; mtip = 1'b1;
        #1;
        checks++; if (irq_cause !== 32'h8000_000B) begin errors++; $display("FAIL prio_all: got %h want %h", irq_cause, 32'h8000_000B); end
        meip = 1'b0;
        #1;
        checks++; if (irq_cause !== 32'h8000_0003) begin errors++; $display("FAIL prio_msi: got %h want %h", irq_cause, 32'h8000_0003); end
        msip = 1'b0;
        #1;
        checks++; if (irq_cause !== 32'h8000_0007) begin errors++; $display("FAIL prio_mti: got %h want %h", irq_cause, 32'h8000_0007); end
        mtip = 1'b0;
        #1;
        checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL prio_none: got %b want 0", irq_take); end
        wr_csr(CSR_OP_RW, CSR_MIE, 32'h0);
    endtask

    task automatic test_warl();
        logic [31:0] v;
        logic        il;
        wr_csr(CSR_OP_RW, CSR_MCAUSE, 32'h8000_0005);
        rd_csr(CSR_MCAUSE, v, il);
        checks++; if (v !== 32'h8000_000B) begin errors++; $display("FAIL mcause_reject: got %h want %h", v, 32'h8000_000B); end
        wr_csr(CSR_OP_RW, CSR_MCAUSE, 32'h0000_0002);
        rd_csr(CSR_MCAUSE, v, il);
        checks++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL mcause_accept: got %h want %h", v, 32'h2); end
        wr_csr(CSR_OP_RW, CSR_MEPC, 32'h0000_1237);
        rd_csr(CSR_MEPC, v, il);
        checks++; if (v !== 32'h0000_1234) begin errors++; $display("FAIL mepc_align: got %h want %h", v, 32'h1234); end
        wr_csr(CSR_OP_RW, CSR_MTVEC, 32'h0000_3002);
        rd_csr(CSR_MTVEC, v, il);
        checks++; if (v !== 32'h0000_3001) begin errors++; $display("FAIL mtvec_mode_warl: got %h want %h", v, 32'h3001); end
        csr_op = CSR_OP_RW;
        csr_id = CSR_MVENDORID;
        wd     = 32'd1;
        #1;
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ro_write_illegal: got %b want 1", illegal); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ro_write_rd: got %h want %h", rd, 32'h0); end
        csr_op = CSR_OP_NONE;
        wd     = '0;
        rd_csr(CSR_MVENDORID, v, il);
        checks++; if (il !== 1'b0) begin errors++; $display("FAIL ro_read_legal: got %b want 0", il); end
    endtask

    task automatic test_counter_wrap();
        logic [31:0] v;
        logic        il;
        wr_csr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
        rd_csr(CSR_MCYCLE, v, il);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_wr_lo: got %h want %h", v, 32'hFFFF_FFFF); end
        rd_csr(CSR_MCYCLEH, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mcycle_wr_hi_kept: got %h want %h", v, 32'h0); end
        tick();
        rd_csr(CSR_MCYCLE, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_lo: got %h want %h", v, 32'h0); end
        rd_csr(CSR_MCYCLEH, v, il);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL mcycle_wrap_hi: got %h want %h", v, 32'h1); end
        wr_csr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
        wr_csr(CSR_OP_RW, CSR_MCYCLEH, 32'h7);
        rd_csr(CSR_MCYCLEH, v, il);
        checks++; if (v !== 32'h7) begin errors++; $display("FAIL mcycleh_write_wins: got %h want %h", v, 32'h7); end
        rd_csr(CSR_MCYCLE, v, il);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_no_inc_on_write: got %h want %h", v, 32'hFFFF_FFFF); end
        wr_csr(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
        rd_csr(CSR_MCOUNTINHIBIT, v, il);
        checks++; if (v !== 32'h0000_003D) begin errors++; $display("FAIL inhibit_mask: got %h want %h", v, 32'h3D); end
        rd_csr(CSR_MCYCLEH, v, il);
        checks++; if (v !== 32'h8) begin errors++; $display("FAIL mcycle_last_inc_hi: got %h want %h", v, 32'h8); end
        tick();
        rd_csr(CSR_MCYCLE, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mcycle_inhibited: got %h want %h", v, 32'h0); end
        wr_csr(CSR_OP_RW, CSR_MINSTRET, 32'h0);
        retire = 1'b1;
        tick();
        tick();
        rd_csr(CSR_MINSTRET, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL minstret_inhibited: got %h want %h", v, 32'h0); end
        wr_csr(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'h0);
        tick();
        tick();
        tick();
        retire = 1'b0;
        rd_csr(CSR_MINSTRET, v, il);
        checks++; if (v !== 32'h3) begin errors++; $display("FAIL minstret_count: got %h want %h", v, 32'h3); end
    endtask

    task automatic test_hpm();
        logic [31:0] v;
        logic        il;
        wr_csr(CSR_OP_RW, CSR_MHPMEVENT3, 32'd2);
        rd_csr(CSR_MHPMEVENT3, v, il);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL hpmevent3_rw: got %h want %h", v, 32'd2); end
        for (int i = 0; i < 2; i++) begin
            hpm_event = 8'b0000_0010;
            tick();
            hpm_event = 8'b0;
            tick();
        end
        hpm_event = 8'b0000_0101;
        tick();
        hpm_event = 8'b0;
        wr_csr(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'h8);
        for (int i = 0; i < 2; i++) begin
            hpm_event = 8'b0000_0010;
            tick();
            hpm_event = 8'b0;
            tick();
        end
        wr_csr(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'h0);
        rd_csr(CSR_MHPMCOUNTER3, v, il);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL hpm3_count: got %h want %h", v, 32'd2); end
        rd_csr(CSR_MHPMCOUNTER3H, v, il);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL hpm3h_count: got %h want %h", v, 32'd0); end
        rd_csr(CSR_MHPMCOUNTER5, v, il);
        checks++; if (il !== 1'b0) begin errors++; $display("FAIL hpm5_legal: got %b want 0", il); end
        csr_op = CSR_OP_RW;
        csr_id = CSR_MHPMCOUNTER6;
        wd     = 32'd1;
        #1;
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL hpm6_illegal: got %b want 1", illegal); end
        csr_op = CSR_OP_NONE;
        wd     = '0;
        wr_csr(CSR_OP_RW, CSR_MHPMEVENT4, 32'd9);
        rd_csr(CSR_MHPMEVENT4, v, il);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL hpmevent_over_range: got %h want %h", v, 32'd0); end
        wr_csr(CSR_OP_RW, CSR_MHPMEVENT4, 32'd8);
        rd_csr(CSR_MHPMEVENT4, v, il);
        checks++; if (v !== 32'd8) begin errors++; $display("FAIL hpmevent_max: got %h want %h", v, 32'd8); end
    endtask

    task automatic test_reset_priority();
        logic [31:0] v;
        logic        il;
        wr_csr(CSR_OP_RW, CSR_MSCRATCH, 32'h55);
        rd_csr(CSR_MSCRATCH, v, il);
        checks++; if (v !== 32'h55) begin errors++; $display("FAIL mscratch_rw: got %h want %h", v, 32'h55); end
        rst        = 1'b1;
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_4000;
        trap_cause = 32'h0000_0003;
        csr_op     = CSR_OP_RW;
        csr_id     = CSR_MSCRATCH;
        wd         = 32'hAA;
        tick();
        rst        = 1'b0;
        trap_valid = 1'b0;
        csr_op     = CSR_OP_NONE;
        wd         = '0;
        rd_csr(CSR_MCYCLE, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mcycle: got %h want %h", v, 32'h0); end
        rd_csr(CSR_MSCRATCH, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mscratch: got %h want %h", v, 32'h0); end
        rd_csr(CSR_MEPC, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mepc: got %h want %h", v, 32'h0); end
        rd_csr(CSR_MHPMEVENT3, v, il);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_hpmevent3: got %h want %h", v, 32'h0); end
    endtask

    initial begin
        rst        = 1'b1;
        csr_op     = CSR_OP_NONE;
        csr_id     = CSR_MSTATUS;
        wd         = '0;
        retire     = 1'b0;
        trap_valid = 1'b0;
        trap_cause = '0;
        trap_pc    = '0;
        trap_tval  = '0;
        mret       = 1'b0;
        mtip       = 1'b0;
        msip       = 1'b0;
        meip       = 1'b0;
        hpm_event  = '0;

        test_reset();
        test_trap_vectored();
        test_mret_priority();
        test_irq_priority();
        test_warl();
        test_counter_wrap();
        test_hpm();
        test_reset_priority();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
